// File: rtl/bound_finder_512bit.sv
// Counts leading zeros of a 512-bit row (from either end) by a 9-step binary search.
// Optional o_empty flag is built when BOUND_FINDER_EMPTY_EN is defined.
module bound_finder_512bit (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_trig,
  input  logic         i_left_or_right,
  input  logic [511:0] i_row,
  output logic         o_done,
  output logic [8:0]   o_bound_index
`ifdef BOUND_FINDER_EMPTY_EN
  , output logic       o_empty
`endif
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    STEP1 = 4'd1,
    STEP2 = 4'd2,
    STEP3 = 4'd3,
    STEP4 = 4'd4,
    STEP5 = 4'd5,
    STEP6 = 4'd6,
    STEP7 = 4'd7,
    STEP8 = 4'd8,
    STEP9 = 4'd9,
    DONE  = 4'd10
  } state_e;

  state_e       state_q;
  logic [511:0] w_q;
  logic [511:0] w_d;
  logic [8:0]   idx_q;
  logic [8:0]   idx_d;
  logic [511:0] row_rev;
  logic [511:0] top_mask;
  logic [9:0]   shamt;
  logic [3:0]   state_num;
  logic [3:0]   bit_sel;

  // Right-mode scans reuse the leading-zero search on the mirrored row.
  for (genvar gi = 0; gi < 512; gi++) begin : g_rev
    assign row_rev[gi] = i_row[511-gi];
  end

  assign state_num = state_q;

  always_comb begin
    shamt    = 10'd512 >> state_num;
    bit_sel  = 4'd9 - state_num;
    top_mask = ~({512{1'b1}} >> shamt);
    w_d      = w_q;
    idx_d    = idx_q;
    if ((w_q & top_mask) == '0) begin
      w_d   = w_q << shamt;
      idx_d = idx_q | (9'd1 << bit_sel);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      w_q     <= '0;
      idx_q   <= '0;
`ifdef BOUND_FINDER_EMPTY_EN
      o_empty <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (i_trig) begin
            state_q <= STEP1;
            w_q     <= i_left_or_right ? row_rev : i_row;
            idx_q   <= '0;
`ifdef BOUND_FINDER_EMPTY_EN
            o_empty <= ~|i_row;
`endif
          end
        end
        STEP1, STEP2, STEP3, STEP4, STEP5, STEP6, STEP7, STEP8: begin
          w_q     <= w_d;
          idx_q   <= idx_d;
          state_q <= state_e'(state_num + 4'd1);
        end
        STEP9: begin
          w_q     <= w_d;
          idx_q   <= idx_d;
          state_q <= DONE;
        end
        DONE: begin
          if (!i_trig) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_done        = (state_q == DONE) && i_trig;
  assign o_bound_index = idx_q;

endmodule

// File: tb/tb_bound_finder_512bit.sv
// Directed self-checking bench for bound_finder_512bit.
module tb_bound_finder_512bit;

  logic         i_clk;
  logic         i_rstn;
  logic         i_trig;
  logic         i_left_or_right;
  logic [511:0] i_row;
  logic         o_done;
  logic [8:0]   o_bound_index;
`ifdef BOUND_FINDER_EMPTY_EN
  logic         o_empty;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bound_finder_512bit dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_trig          (i_trig),
    .i_left_or_right (i_left_or_right),
    .i_row           (i_row),
    .o_done          (o_done),
    .o_bound_index   (o_bound_index)
`ifdef BOUND_FINDER_EMPTY_EN
    , .o_empty       (o_empty)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Starts a scan and reports the edge count at which o_done first rose (-1 if never).
  task automatic run_scan(input logic [511:0] row, input logic lr,
                          output int done_cyc, output logic [8:0] idx);
    @(negedge i_clk);
    i_row = row;
    i_left_or_right = lr;
    i_trig = 1'b1;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge i_clk);
      #1;
      if (o_done) begin
        done_cyc = c;
        break;
      end
    end
    idx = o_bound_index;
    @(negedge i_clk);
    i_trig = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rstn = 1'b0;
    i_trig = 1'b0;
    i_left_or_right = 1'b0;
    i_row = '0;
    #23;
    n_cmp++;
    if (o_bound_index !== 9'd0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got idx=%0d done=%b, want idx=0 done=0", o_bound_index, o_done);
    end
`ifdef BOUND_FINDER_EMPTY_EN
    n_cmp++;
    if (o_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_empty: got %b, want 0", o_empty);
    end
`endif
    @(negedge i_clk);
    i_rstn = 1'b1;
    $display("reset: idx=%0d done=%b", o_bound_index, o_done);
  endtask

  task automatic test_single_bits;
    logic [511:0] r;
    logic [8:0]   idx;
    int           dc;
    r = '0; r[511] = 1'b1;
    run_scan(r, 1'b0, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd0) begin
      n_bad++;
      $display("FAIL bit511_left: got done_edge=%0d idx=%0d, want done_edge=10 idx=0", dc, idx);
    end
    n_cmp++;
    if (o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_drop: got o_done=%b after trig low, want 0", o_done);
    end
    $display("bit511 left: done_edge=%0d idx=%0d", dc, idx);
    r = '0; r[0] = 1'b1;
    run_scan(r, 1'b0, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd511) begin
      n_bad++;
      $display("FAIL bit0_left: got done_edge=%0d idx=%0d, want done_edge=10 idx=511", dc, idx);
    end
    $display("bit0 left: done_edge=%0d idx=%0d", dc, idx);
    run_scan(r, 1'b1, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd0) begin
      n_bad++;
      $display("FAIL bit0_right: got done_edge=%0d idx=%0d, want done_edge=10 idx=0", dc, idx);
    end
    $display("bit0 right: done_edge=%0d idx=%0d", dc, idx);
    n_cmp++;
    if (o_bound_index !== 9'd0) begin
      n_bad++;
      $display("FAIL hold_idle: got idx=%0d in IDLE, want 0", o_bound_index);
    end
  endtask

  task automatic test_two_bits;
    logic [511:0] r;
    logic [8:0]   idx;
    int           dc;
    r = '0; r[300] = 1'b1; r[5] = 1'b1;
    run_scan(r, 1'b0, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd211) begin
      n_bad++;
      $display("FAIL two_bits_left: got done_edge=%0d idx=%0d, want done_edge=10 idx=211", dc, idx);
    end
    $display("bits300+5 left: idx=%0d", idx);
    run_scan(r, 1'b1, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd5) begin
      n_bad++;
      $display("FAIL two_bits_right: got done_edge=%0d idx=%0d, want done_edge=10 idx=5", dc, idx);
    end
    $display("bits300+5 right: idx=%0d", idx);
  endtask

  task automatic test_empty_row;
    logic [511:0] r;
    logic [8:0]   idx;
    int           dc;
    for (int m = 0; m < 2; m++) begin
      run_scan('0, m[0], dc, idx);
      n_cmp++;
      if (dc !== 10 || idx !== 9'd511) begin
        n_bad++;
        $display("FAIL zero_row_mode%0d: got done_edge=%0d idx=%0d, want done_edge=10 idx=511", m, dc, idx);
      end
`ifdef BOUND_FINDER_EMPTY_EN
      n_cmp++;
      if (o_empty !== 1'b1) begin
        n_bad++;
        $display("FAIL zero_row_empty%0d: got %b, want 1", m, o_empty);
      end
`endif
      $display("zero row mode %0d: idx=%0d", m, idx);
    end
    r = '0; r[16] = 1'b1;
    run_scan(r, 1'b1, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd16) begin
      n_bad++;
      $display("FAIL bit16_right: got done_edge=%0d idx=%0d, want done_edge=10 idx=16", dc, idx);
    end
`ifdef BOUND_FINDER_EMPTY_EN
    n_cmp++;
    if (o_empty !== 1'b0) begin
      n_bad++;
      $display("FAIL bit16_empty: got %b, want 0", o_empty);
    end
`endif
    $display("bit16 right: idx=%0d", idx);
  endtask

  task automatic test_mid_reset;
    logic [511:0] r;
    logic [8:0]   idx;
    int           dc;
    int           seen;
    r = '0; r[100] = 1'b1;
    @(negedge i_clk);
    i_row = r;
    i_left_or_right = 1'b0;
    i_trig = 1'b1;
    repeat (5) @(posedge i_clk);
    #1;
    i_rstn = 1'b0;
    i_trig = 1'b0;
    #2;
    n_cmp++;
    if (o_bound_index !== 9'd0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got idx=%0d done=%b, want idx=0 done=0", o_bound_index, o_done);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge i_clk);
      #1;
      if (o_done || o_bound_index != 9'd0) seen = 1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_discard: got activity=%0d after reset, want 0", seen);
    end
    $display("mid reset: idx=%0d done=%b", o_bound_index, o_done);
    r = '0; r[384] = 1'b1;
    run_scan(r, 1'b0, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd127) begin
      n_bad++;
      $display("FAIL bit384_left: got done_edge=%0d idx=%0d, want done_edge=10 idx=127", dc, idx);
    end
    $display("bit384 left: idx=%0d", idx);
  endtask

  task automatic test_trig_drop;
    logic [511:0] r;
    logic [511:0] r2;
    logic [8:0]   idx;
    int           dc;
    int           seen;
    r = '0; r[300] = 1'b1; r[5] = 1'b1;
    r2 = '0; r2[511] = 1'b1;
    @(negedge i_clk);
    i_row = r;
    i_left_or_right = 1'b0;
    i_trig = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_trig = 1'b0;
    i_row = r2;
    i_left_or_right = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge i_clk);
      #1;
      if (o_done) seen = 1;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL trig_drop_done: got o_done pulse=%0d, want 0", seen);
    end
    n_cmp++;
    if (o_bound_index !== 9'd211) begin
      n_bad++;
      $display("FAIL trig_drop_result: got idx=%0d, want 211", o_bound_index);
    end
    $display("trig drop: idx=%0d", o_bound_index);
    // Block must be back in IDLE and accept a fresh scan with normal latency.
    run_scan(r2, 1'b0, dc, idx);
    n_cmp++;
    if (dc !== 10 || idx !== 9'd0) begin
      n_bad++;
      $display("FAIL after_drop_scan: got done_edge=%0d idx=%0d, want done_edge=10 idx=0", dc, idx);
    end
    $display("after drop scan: done_edge=%0d idx=%0d", dc, idx);
  endtask

  initial begin
    test_reset();
    test_single_bits();
    test_two_bits();
    test_empty_row();
    test_mid_reset();
    test_trig_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bound_finder_512bit.md
BOUND_FINDER_512BIT -- requirements
Module: bound_finder_512bit

Interface
REQ-001 SHALL have ports: i_clk  in  1  rising-edge clock.
REQ-002 SHALL have: i_rstn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: i_trig  in  1  start request; held high by the controller until o_done is seen, then lowered.
REQ-004 SHALL have: i_left_or_right  in  1  0 = count zeros from MSB (bit 511) side; 1 = count zeros from LSB (bit 0) side.
REQ-005 SHALL have: i_row  in  512  pixel row to scan.
REQ-006 SHALL have: o_done  out  1  result valid; equals (state==DONE) AND i_trig.
REQ-007 SHALL have: o_bound_index  out  9  zero-run length, encoded to drive a 9-bit mask-generator bound index directly.
REQ-008 SHALL have, when BOUND_FINDER_EMPTY_EN is defined: o_empty  out  1  row contained no set bit.

Function
REQ-009 SHALL implement a state machine with 11 states: IDLE, STEP1..STEP9, DONE.
REQ-010 IDLE SHALL go to STEP1 when i_trig=1, else stay in IDLE.
REQ-011 STEPk SHALL go to STEPk+1 for k=1..8; STEP9 SHALL go to DONE.
REQ-012 DONE SHALL go to IDLE when i_trig=0, else stay in DONE; an undefined state SHALL go to IDLE.
REQ-013 On acceptance (IDLE and i_trig=1) SHALL latch the working vector w:
- i_left_or_right=0: w = i_row.
- i_left_or_right=1: w = bit-reversed i_row.
- o_bound_index SHALL clear to 0.
REQ-014 In STEPk (W = 2^(9-k), i.e. 256,128,...,1), if w[511:512-W] is all zero, SHALL set o_bound_index bit (9-k) and shift w left by W; otherwise w and the index are unchanged.
REQ-015 Result SHALL be the count of leading zeros of w, i.e.:
- left mode: 511 minus the highest set bit position;
- right mode: the lowest set bit position.
REQ-016 An all-zero row SHALL yield o_bound_index=511 (saturated; 512 is not representable).
REQ-017 Latency: with i_trig high before rising edge 1, DONE SHALL be entered at edge 10 and o_done SHALL be high from then on while i_trig=1.
REQ-018 i_row and i_left_or_right SHALL be sampled only at acceptance; changes afterwards SHALL have no effect.
REQ-019 Dropping i_trig mid-scan SHALL NOT abort the scan; the block SHALL reach DONE, then return to IDLE with o_done low throughout.
REQ-020 o_bound_index (and o_empty) SHALL hold their values in DONE and IDLE until the next acceptance.

Reset
REQ-021 i_rstn low SHALL asynchronously force state=IDLE, w=0, o_bound_index=0, o_empty=0, o_done=0.
REQ-022 A reset during STEP1..STEP9 SHALL discard the scan; no o_done pulse SHALL follow release until a new i_trig.

Configuration
REQ-023 With BOUND_FINDER_EMPTY_EN defined:
- o_empty SHALL be registered at acceptance as NOR of i_row.
- o_empty SHALL be held until the next acceptance or reset.
REQ-024 Without BOUND_FINDER_EMPTY_EN:
- port o_empty and its logic SHALL be absent.
- All other behaviour SHALL be identical.

Verification
REQ-025 Only bit 511 set, left mode -> o_bound_index=0, o_done at edge 10.
REQ-026 Only bit 0 set -> left mode gives 511, right mode gives 0.
REQ-027 Bits 300 and 5 set -> left mode gives 211; right mode gives 5.
REQ-028 All-zero row, both modes -> o_bound_index=511, o_empty=1 (macro on); a following row with bit 16 set, right mode -> 16, o_empty=0.
REQ-029 i_rstn pulsed low during STEP5 -> outputs 0, state IDLE, no o_done; new trig with bit 384 set, left mode -> 127.
REQ-030 i_trig dropped at STEP3 -> o_done never asserts; block returns to IDLE one cycle after DONE; i_row changed after acceptance -> result unaffected.
